// File: rtl/tcam_rule_loader.sv
// Buffers host rule writes in a small FIFO and sequences them onto the TCAM set interface.
// Optional feature macro: TCAM_SEARCH_HOLD_EN (search stall during update plus DRAIN-cycle gap).
module tcam_rule_loader #(
    parameter int IDWID     = 8,
    parameter int TOTALWID  = 125,
    parameter int FIFO_AWID = 2,
    parameter int TIMEOUT   = 64,
    parameter int DRAIN     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_Req_Valid,
    output logic                o_Req_Ready,
    input  logic [IDWID-1:0]    i_Req_ID,
    input  logic [TOTALWID-1:0] i_Req_String,
    output logic [IDWID-1:0]    o_Set_ID,
    output logic [TOTALWID-1:0] o_Set_String,
    output logic                o_Set_Enable,
    input  logic                i_Set_Done,
    output logic                o_Busy,
    output logic                o_Search_Hold,
    output logic [15:0]         o_Update_Count,
    output logic                o_Err_Timeout,
    input  logic                i_Err_Clear
);
    localparam int DEPTH   = 1 << FIFO_AWID;
    localparam int CNT_MAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
`ifdef TCAM_SEARCH_HOLD_EN
    localparam logic HOLD_EN = 1'b1;
    localparam int   GAP_LEN = DRAIN;
`else
    localparam logic HOLD_EN = 1'b0;
    localparam int   GAP_LEN = 1;
`endif
    // The counter is checked one short of TIMEOUT-1 so the flag is visible TIMEOUT cycles after ISSUE.
    localparam logic [CNTW-1:0]      TIMEOUT_LAST = CNTW'(TIMEOUT - 2);
    localparam logic [CNTW-1:0]      GAP_LAST     = CNTW'(GAP_LEN - 1);
    localparam logic [CNTW-1:0]      CNT_ONE      = CNTW'(1'b1);
    localparam logic [FIFO_AWID:0]   PTR_ONE      = {{FIFO_AWID{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t                        state_r;
    logic [IDWID+TOTALWID-1:0]     mem_r [DEPTH];
    logic [FIFO_AWID:0]            wr_ptr_r;
    logic [FIFO_AWID:0]            rd_ptr_r;
    logic [CNTW-1:0]               cnt_r;
    logic [IDWID-1:0]              set_id_r;
    logic [TOTALWID-1:0]           set_string_r;
    logic                          set_enable_r;
    logic                          hold_r;
    logic [15:0]                   count_r;
    logic                          err_r;
    logic                          full_s;
    logic                          empty_s;
    logic                          push_s;
    logic                          pop_s;
    logic                          timeout_s;
    logic                          gap_last_s;
    logic [IDWID+TOTALWID-1:0]     head_s;

    assign full_s     = (wr_ptr_r[FIFO_AWID] != rd_ptr_r[FIFO_AWID]) &&
                        (wr_ptr_r[FIFO_AWID-1:0] == rd_ptr_r[FIFO_AWID-1:0]);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign push_s     = i_Req_Valid && !full_s;
    assign pop_s      = (state_r == IDLE) && !empty_s;
    assign timeout_s  = (state_r == WAIT) && !i_Set_Done && (cnt_r == TIMEOUT_LAST);
    assign gap_last_s = (cnt_r == GAP_LAST);
    assign head_s     = mem_r[rd_ptr_r[FIFO_AWID-1:0]];

    assign o_Req_Ready    = !full_s;
    assign o_Busy         = (state_r != IDLE) || !empty_s;
    assign o_Set_ID       = set_id_r;
    assign o_Set_String   = set_string_r;
    assign o_Set_Enable   = set_enable_r;
    assign o_Search_Hold  = hold_r;
    assign o_Update_Count = count_r;
    assign o_Err_Timeout  = err_r;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[FIFO_AWID-1:0]] <= {i_Req_ID, i_Req_String};
        end
    end

    // FIFO pointers, wrapping naturally at FIFO_AWID+1 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Update sequencer with registered set interface, hold and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            set_id_r     <= '0;
            set_string_r <= '0;
            set_enable_r <= 1'b0;
            hold_r       <= 1'b0;
            count_r      <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        {set_id_r, set_string_r} <= head_s;
                        set_enable_r <= 1'b1;
                        hold_r       <= HOLD_EN;
                        state_r      <= ISSUE;
                    end else begin
                        set_enable_r <= 1'b0;
                        hold_r       <= 1'b0;
                    end
                end
                ISSUE: begin
                    set_enable_r <= 1'b0;
                    cnt_r        <= '0;
                    hold_r       <= HOLD_EN;
                    state_r      <= WAIT;
                end
                WAIT: begin
                    hold_r <= HOLD_EN;
                    if (i_Set_Done) begin
                        count_r <= count_r + 16'd1;
                        cnt_r   <= '0;
                        state_r <= GAP;
                    end else if (timeout_s) begin
                        cnt_r   <= '0;
                        state_r <= GAP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                GAP: begin
                    if (gap_last_s) begin
                        cnt_r   <= '0;
                        hold_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        hold_r <= HOLD_EN;
                    end
                end
                default: begin
                    set_enable_r <= 1'b0;
                    hold_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else if (i_Err_Clear) begin
            err_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tcam_rule_loader.sv
// Self-checking bench for tcam_rule_loader: directed timing scenarios plus a randomized stream
// checked against a push-order queue model and a count of completions.
module tb_tcam_rule_loader;
    localparam int IDWID    = 8;
    localparam int TOTALWID = 125;
    localparam int TIMEOUT  = 64;
    localparam int DRAIN    = 10;
`ifdef TCAM_SEARCH_HOLD_EN
    localparam int HOLD_CYCLES = 1 + 2 + DRAIN;
`else
    localparam int HOLD_CYCLES = 0;
`endif

    typedef struct {
        logic [IDWID-1:0]    id;
        logic [TOTALWID-1:0] str;
    } entry_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                i_Req_Valid = 1'b0;
    logic                o_Req_Ready;
    logic [IDWID-1:0]    i_Req_ID = '0;
    logic [TOTALWID-1:0] i_Req_String = '0;
    logic [IDWID-1:0]    o_Set_ID;
    logic [TOTALWID-1:0] o_Set_String;
    logic                o_Set_Enable;
    logic                i_Set_Done = 1'b0;
    logic                o_Busy;
    logic                o_Search_Hold;
    logic [15:0]         o_Update_Count;
    logic                o_Err_Timeout;
    logic                i_Err_Clear = 1'b0;

    int     tests_run = 0;
    int     fails = 0;
    int     en_total = 0;
    logic   prev_en = 1'b0;
    logic [15:0] exp_count = 16'd0;
    entry_t q[$];

    tcam_rule_loader #(
        .IDWID(IDWID), .TOTALWID(TOTALWID), .FIFO_AWID(2), .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)
    ) dut (
        .clk(clk), .rst(rst),
        .i_Req_Valid(i_Req_Valid), .o_Req_Ready(o_Req_Ready),
        .i_Req_ID(i_Req_ID), .i_Req_String(i_Req_String),
        .o_Set_ID(o_Set_ID), .o_Set_String(o_Set_String), .o_Set_Enable(o_Set_Enable),
        .i_Set_Done(i_Set_Done), .o_Busy(o_Busy), .o_Search_Hold(o_Search_Hold),
        .o_Update_Count(o_Update_Count), .o_Err_Timeout(o_Err_Timeout), .i_Err_Clear(i_Err_Clear)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; every write strobe must be a single cycle and carry the oldest accepted request.
    task automatic step();
        entry_t e;
        @(posedge clk);
        #1;
        if (rst === 1'b1 && o_Set_Enable === 1'b1) begin
            tests_run++;
            if (prev_en !== 1'b0) begin
                fails++;
                $display("FAIL enable_pulse: enable high two cycles running, required single cycle");
            end
            tests_run++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL issue_unexpected: write strobe with id %0h but no request pending", o_Set_ID);
            end else begin
                e = q.pop_front();
                if (o_Set_ID !== e.id || o_Set_String !== e.str) begin
                    fails++;
                    $display("FAIL issue_order: id %0h str %0h, required id %0h str %0h",
                             o_Set_ID, o_Set_String, e.id, e.str);
                end
            end
        end
        prev_en = o_Set_Enable;
        if (o_Set_Enable === 1'b1) en_total++;
    endtask

    task automatic push(input logic [IDWID-1:0] id, input logic [TOTALWID-1:0] str);
        entry_t e;
        bit done_push = 1'b0;
        i_Req_Valid  = 1'b1;
        i_Req_ID     = id;
        i_Req_String = str;
        for (int i = 0; i < 300 && !done_push; i++) begin
            if (o_Req_Ready === 1'b1) begin
                e.id = id;
                e.str = str;
                q.push_back(e);
                done_push = 1'b1;
            end
            step();
        end
        i_Req_Valid = 1'b0;
        tests_run++;
        if (!done_push) begin
            fails++;
            $display("FAIL push_accept: ready never high, required acceptance within 300 cycles");
        end
    endtask

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            if (o_Set_Enable === 1'b1) ok = 1'b1;
        end
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_enable: no write strobe within 300 cycles, required one");
        end
    endtask

    task automatic done_after(input int d);
        repeat (d) step();
        i_Set_Done = 1'b1;
        step();
        i_Set_Done = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({o_Req_Ready, o_Set_Enable, o_Busy, o_Search_Hold, o_Err_Timeout} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_flags: rdy/en/busy/hold/err %b, required 10000",
                     {o_Req_Ready, o_Set_Enable, o_Busy, o_Search_Hold, o_Err_Timeout});
        end
        tests_run++;
        if (o_Set_ID !== '0 || o_Set_String !== '0 || o_Update_Count !== 16'd0) begin
            fails++;
            $display("FAIL reset_data: id %0h str %0h count %0d, required all 0",
                     o_Set_ID, o_Set_String, o_Update_Count);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        push(8'h05, 125'h1_ABCD);
        tests_run++;
        if (o_Set_Enable !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: enable %b one cycle after push, required 0", o_Set_Enable);
        end
        step();
        tests_run++;
        if (o_Set_Enable !== 1'b1 || o_Set_ID !== 8'h05) begin
            fails++;
            $display("FAIL latency_issue: enable %b id %0h two cycles after push, required 1 and 05",
                     o_Set_Enable, o_Set_ID);
        end
        step();
        done_after(1);
        tests_run++;
        if (o_Update_Count !== exp_count) begin
            fails++;
            $display("FAIL single_count: count %0d, required %0d", o_Update_Count, exp_count);
        end
        repeat (GAP_CYCLES()) step();
        tests_run++;
        if (o_Busy !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: busy %b after gap, required 0", o_Busy);
        end
    endtask

    function automatic int GAP_CYCLES();
`ifdef TCAM_SEARCH_HOLD_EN
        return DRAIN;
`else
        return 1;
`endif
    endfunction

    task automatic test_fill();
        bit ok;
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 125'({$urandom, $urandom, $urandom, $urandom}));
        tests_run++;
        if (o_Req_Ready !== 1'b0 || o_Busy !== 1'b1) begin
            fails++;
            $display("FAIL fill_ready: ready %b busy %b after 5 pushes, required 0 and 1",
                     o_Req_Ready, o_Busy);
        end
        done_after(0);
        for (int i = 0; i < 4; i++) begin
            wait_enable(ok);
            if (ok) done_after($urandom_range(1, 5));
        end
        repeat (GAP_CYCLES() + 3) step();
        tests_run++;
        if (o_Update_Count !== exp_count || o_Busy !== 1'b0 || q.size() != 0) begin
            fails++;
            $display("FAIL fill_drain: count %0d busy %b pending %0d, required %0d 0 0",
                     o_Update_Count, o_Busy, q.size(), exp_count);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        push(8'hA1, 125'h5555);
        wait_enable(ok);
        push(8'hA2, 125'h6666);
        k = 1;
        while (o_Err_Timeout !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        tests_run++;
        if (k != TIMEOUT) begin
            fails++;
            $display("FAIL timeout_lag: flag rose %0d cycles after issue, required %0d", k, TIMEOUT);
        end
        tests_run++;
        if (o_Update_Count !== exp_count) begin
            fails++;
            $display("FAIL timeout_count: count %0d, required %0d", o_Update_Count, exp_count);
        end
        wait_enable(ok);
        if (ok) done_after(3);
        tests_run++;
        if (o_Err_Timeout !== 1'b1 || o_Update_Count !== exp_count) begin
            fails++;
            $display("FAIL timeout_sticky: err %b count %0d, required 1 and %0d",
                     o_Err_Timeout, o_Update_Count, exp_count);
        end
        i_Err_Clear = 1'b1;
        step();
        i_Err_Clear = 1'b0;
        tests_run++;
        if (o_Err_Timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: err %b after clear, required 0", o_Err_Timeout);
        end
        repeat (GAP_CYCLES() + 3) step();
    endtask

    task automatic test_ignored_done();
        bit ok;
        i_Set_Done = 1'b1;
        step();
        i_Set_Done = 1'b0;
        tests_run++;
        if (o_Update_Count !== exp_count || o_Busy !== 1'b0) begin
            fails++;
            $display("FAIL done_idle: count %0d busy %b, required %0d and 0",
                     o_Update_Count, o_Busy, exp_count);
        end
        push(8'h3C, 125'h1234_5678);
        wait_enable(ok);
        i_Set_Done = 1'b1;
        step();
        i_Set_Done = 1'b0;
        repeat (5) step();
        tests_run++;
        if (o_Update_Count !== exp_count || o_Busy !== 1'b1) begin
            fails++;
            $display("FAIL done_issue: count %0d busy %b, required %0d and 1",
                     o_Update_Count, o_Busy, exp_count);
        end
        done_after(0);
        tests_run++;
        if (o_Update_Count !== exp_count) begin
            fails++;
            $display("FAIL done_wait: count %0d, required %0d", o_Update_Count, exp_count);
        end
        repeat (GAP_CYCLES() + 3) step();
    endtask

    task automatic test_search_hold();
        int total = 0;
        int run = 0;
        int maxrun = 0;
        int e_cyc = -1;
        push(8'h77, 125'hBEEF);
        for (int cyc = 0; cyc < 40; cyc++) begin
            i_Set_Done = (e_cyc >= 0 && cyc == e_cyc + 2);
            if (o_Search_Hold === 1'b1) begin
                total++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (o_Set_Enable === 1'b1 && e_cyc < 0) e_cyc = cyc;
            step();
        end
        i_Set_Done = 1'b0;
        exp_count++;
        tests_run++;
        if (total != HOLD_CYCLES || maxrun != HOLD_CYCLES) begin
            fails++;
            $display("FAIL search_hold: %0d hold cycles (longest run %0d), required %0d contiguous",
                     total, maxrun, HOLD_CYCLES);
        end
        tests_run++;
        if (o_Update_Count !== exp_count) begin
            fails++;
            $display("FAIL hold_count: count %0d, required %0d", o_Update_Count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int en_before;
        for (int i = 0; i < 3; i++) push(8'(8'h50 + i), 125'({$urandom, $urandom, $urandom, $urandom}));
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({o_Req_Ready, o_Set_Enable, o_Busy, o_Search_Hold, o_Err_Timeout} !== 5'b10000 ||
            o_Set_ID !== '0 || o_Set_String !== '0 || o_Update_Count !== 16'd0) begin
            fails++;
            $display("FAIL midreset_async: rdy/en/busy/hold/err %b id %0h count %0d, required 10000 0 0",
                     {o_Req_Ready, o_Set_Enable, o_Busy, o_Search_Hold, o_Err_Timeout},
                     o_Set_ID, o_Update_Count);
        end
        q.delete();
        exp_count = 16'd0;
        step();
        tests_run++;
        if ({o_Req_Ready, o_Set_Enable, o_Busy} !== 3'b100 || o_Update_Count !== 16'd0) begin
            fails++;
            $display("FAIL midreset_edge: rdy/en/busy %b count %0d, required 100 0",
                     {o_Req_Ready, o_Set_Enable, o_Busy}, o_Update_Count);
        end
        rst = 1'b1;
        en_before = en_total;
        repeat (20) step();
        tests_run++;
        if (en_total != en_before || o_Busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_flush: %0d strobes busy %b after release, required 0 and 0",
                     en_total - en_before, o_Busy);
        end
        push(8'h99, 125'h42);
        wait_enable(ok);
        if (ok) done_after(2);
        tests_run++;
        if (o_Update_Count !== exp_count) begin
            fails++;
            $display("FAIL midreset_resume: count %0d, required %0d", o_Update_Count, exp_count);
        end
        repeat (GAP_CYCLES() + 3) step();
    endtask

    task automatic test_random_stream();
        entry_t e;
        int pushed = 0;
        int updates = 0;
        int wait_cnt = 0;
        int cyc = 0;
        while (updates < 12 && cyc < 3000) begin
            i_Set_Done = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    i_Set_Done = 1'b1;
                    updates++;
                    exp_count++;
                end
            end
            if (o_Set_Enable === 1'b1) wait_cnt = $urandom_range(1, 6);
            if (pushed < 12 && $urandom_range(0, 1) == 1) begin
                i_Req_Valid  = 1'b1;
                i_Req_ID     = 8'($urandom);
                i_Req_String = 125'({$urandom, $urandom, $urandom, $urandom});
                if (o_Req_Ready === 1'b1) begin
                    e.id = i_Req_ID;
                    e.str = i_Req_String;
                    q.push_back(e);
                    pushed++;
                end
            end else begin
                i_Req_Valid = 1'b0;
            end
            step();
            cyc++;
        end
        i_Req_Valid = 1'b0;
        i_Set_Done = 1'b0;
        repeat (GAP_CYCLES() + 3) step();
        tests_run++;
        if (updates != 12 || o_Update_Count !== exp_count || o_Busy !== 1'b0 || q.size() != 0) begin
            fails++;
            $display("FAIL random_stream: updates %0d count %0d busy %b pending %0d, required 12 %0d 0 0",
                     updates, o_Update_Count, o_Busy, q.size(), exp_count);
        end
        tests_run++;
        if (o_Err_Timeout !== 1'b0) begin
            fails++;
            $display("FAIL random_err: err %b, required 0", o_Err_Timeout);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_timeout();
        test_ignored_done();
        test_search_hold();
        test_reset_mid();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/tcam_rule_loader.md
# tcam_rule_loader

Update controller that sequences rule writes into the TCAM setting interface (Set ID / Set String / Set Enable / Set Done). Rule updates from a host-side requester are buffered in a small FIFO and issued one at a time. Each update waits for set-done completion, with a timeout guard. Optionally, the block stalls the search key source while an update is in flight and while the 8-stage search pipeline drains.

## Interface
Parameters:
- IDWID, 8, rule ID width
- TOTALWID, 125, rule string width (104 key + 13 mask + 8 priority)
- FIFO_AWID, 2, request FIFO address width; depth = 1<<FIFO_AWID
- TIMEOUT, 64, max cycles spent in WAIT before abort
- DRAIN, 10, post-update search-hold cycles (used only with TCAM_SEARCH_HOLD_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_Req_Valid  in  1  rule request valid
- o_Req_Ready  out  1  FIFO not full
- i_Req_ID  in  IDWID  rule ID to write
- i_Req_String  in  TOTALWID  rule string to write
- o_Set_ID  out  IDWID  to TCAM Set ID
- o_Set_String  out  TOTALWID  to TCAM Set String
- o_Set_Enable  out  1  one-cycle write strobe to TCAM
- i_Set_Done  in  1  completion pulse from TCAM
- o_Busy  out  1  state != IDLE or FIFO not empty
- o_Search_Hold  out  1  stall request to key source
- o_Update_Count  out  16  successful updates, wraps
- o_Err_Timeout  out  1  sticky timeout flag
- i_Err_Clear  in  1  clears o_Err_Timeout

## Operation
- Request accepted when i_Req_Valid && o_Req_Ready; written at FIFO tail. o_Req_Ready = !full and is independent of i_Req_Valid.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE: if FIFO non-empty, pop head into o_Set_ID/o_Set_String and go to ISSUE.
- ISSUE: o_Set_Enable = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: if i_Set_Done, increment o_Update_Count and go to GAP. Otherwise increment the counter; when the counter reaches TIMEOUT-1 with no done, set o_Err_Timeout, drop the entry without a count, and go to GAP.
- GAP: 1 cycle (DRAIN cycles with macro), then go to IDLE.
- o_Set_ID/o_Set_String hold stable from ISSUE through the end of GAP. They change only on a pop.
- i_Set_Done is sampled only in WAIT and ignored in every other state, including the ISSUE cycle.
- Pushing into a full FIFO is impossible by construction. Push and pop in the same cycle are both performed; occupancy is unchanged.
- i_Err_Clear clears o_Err_Timeout. If clear and timeout occur in the same cycle, set wins.
- FIFO pointers are FIFO_AWID+1 bits. Full is detected when the MSBs differ and the rest are equal. Both pointers wrap naturally.

## Timing
- Reset values: o_Req_Ready=1, o_Set_Enable=0, o_Set_ID=0, o_Set_String=0, o_Busy=0, o_Search_Hold=0, o_Update_Count=0, o_Err_Timeout=0, state=IDLE, FIFO empty.
- Reset asserted mid-operation aborts the update immediately. The FIFO is flushed and no further o_Set_Enable is issued.
- All outputs are registered except o_Req_Ready and o_Busy, which are combinational from registers.
- Latency: handshake in cycle N with FIFO empty and FSM in IDLE → o_Set_Enable high in cycle N+2.
- Back-to-back throughput with done arriving 1 cycle after enable: one update per 4 cycles (ISSUE, WAIT, GAP, IDLE) without macro.
- Timeout: o_Err_Timeout rises TIMEOUT cycles after the ISSUE cycle.

## Configuration
- Macro: TCAM_SEARCH_HOLD_EN.
- Defined:
  - o_Search_Hold = 1 in ISSUE, WAIT and GAP.
  - GAP lasts DRAIN cycles, so in-flight searches using stale rules flush before the key source resumes.
- Undefined:
  - o_Search_Hold is tied to 0.
  - GAP lasts 1 cycle.
  - DRAIN is unused.

## Test plan
- Reset, then push ID=0x05, string=125'h1_ABCD in cycle 10 → o_Set_Enable pulses for one cycle in cycle 12 with o_Set_ID=0x05; i_Set_Done in cycle 14 → o_Update_Count=1, o_Busy=0 by cycle 16.
- Push 5 requests back-to-back with FIFO_AWID=2 and done withheld → o_Req_Ready low after the 4th FIFO entry while the 1st entry is in WAIT. Releasing done per update → IDs issued in push order, count=5.
- Never assert done, TIMEOUT=64 → o_Err_Timeout=1 exactly 64 cycles after the ISSUE cycle, count unchanged, next entry issued. Assert i_Err_Clear → flag returns to 0.
- Pulse i_Set_Done in the ISSUE cycle and in IDLE → both ignored; the update completes only on a later done seen in WAIT.
- Drop rst low while in WAIT with 2 entries queued → all outputs at reset values next edge; no o_Set_Enable after release until a new push.
- With TCAM_SEARCH_HOLD_EN, DRAIN=10, done 2 cycles after enable → o_Search_Hold high for 1+2+10=13 consecutive cycles. Without the macro it stays at 0.
